// File: rtl/aibcr3aux_red_pkg.sv
// Shared types and helpers for the aux redundancy chain loader.
// Optional readback support is enabled with AUX_RED_READBACK_EN.
package aibcr3aux_red_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    APPLY
  } state_t;

  localparam int SEL_CH1 = 0;
  localparam int SEL_CH2 = 1;

  function automatic bit div_ok(input int div);
    return (div >= 2) && (div % 2 == 0);
  endfunction

endpackage

// File: rtl/aibcr3aux_red_chain_ld_if.sv
// Load handshake and chain-side signals of the redundancy loader.
// AUX_RED_READBACK_EN adds scan-out inputs and readback outputs.
interface aibcr3aux_red_chain_ld_if #(
  parameter int CHAIN_LEN = 48
);
  logic                 i_ld_req;
  logic [1:0]           i_ld_sel;
  logic [CHAIN_LEN-1:0] i_ld_data1;
  logic [CHAIN_LEN-1:0] i_ld_data2;
  logic                 o_ld_busy;
  logic                 o_ld_done;
  logic                 o_actred1;
  logic                 o_actred2;
  logic                 o_red_clk;
  logic                 o_shift_en_chain1;
  logic                 o_shift_en_chain2;
  logic                 o_idataselb_chain1;
  logic                 o_idataselb_chain2;
  logic                 o_actred_txen1;
  logic                 o_actred_txen2;
`ifdef AUX_RED_READBACK_EN
  logic                 i_red_so1;
  logic                 i_red_so2;
  logic [CHAIN_LEN-1:0] o_rb_data1;
  logic [CHAIN_LEN-1:0] o_rb_data2;
  logic                 o_rb_valid;

  modport master (
    output i_ld_req, i_ld_sel, i_ld_data1, i_ld_data2,
    output i_red_so1, i_red_so2,
    input  o_ld_busy, o_ld_done, o_actred1, o_actred2,
    input  o_red_clk, o_shift_en_chain1, o_shift_en_chain2,
    input  o_idataselb_chain1, o_idataselb_chain2,
    input  o_actred_txen1, o_actred_txen2,
    input  o_rb_data1, o_rb_data2, o_rb_valid
  );

  modport slave (
    input  i_ld_req, i_ld_sel, i_ld_data1, i_ld_data2,
    input  i_red_so1, i_red_so2,
    output o_ld_busy, o_ld_done, o_actred1, o_actred2,
    output o_red_clk, o_shift_en_chain1, o_shift_en_chain2,
    output o_idataselb_chain1, o_idataselb_chain2,
    output o_actred_txen1, o_actred_txen2,
    output o_rb_data1, o_rb_data2, o_rb_valid
  );
`else
  modport master (
    output i_ld_req, i_ld_sel, i_ld_data1, i_ld_data2,
    input  o_ld_busy, o_ld_done, o_actred1, o_actred2,
    input  o_red_clk, o_shift_en_chain1, o_shift_en_chain2,
    input  o_idataselb_chain1, o_idataselb_chain2,
    input  o_actred_txen1, o_actred_txen2
  );

  modport slave (
    input  i_ld_req, i_ld_sel, i_ld_data1, i_ld_data2,
    output o_ld_busy, o_ld_done, o_actred1, o_actred2,
    output o_red_clk, o_shift_en_chain1, o_shift_en_chain2,
    output o_idataselb_chain1, o_idataselb_chain2,
    output o_actred_txen1, o_actred_txen2
  );
`endif
endinterface

// File: rtl/aibcr3aux_red_bittmr.sv
// Bit-period phase counter: wraps at DIV-1, cleared on FSM state change.
// AUX_RED_READBACK_EN adds a pre-rise strobe for scan-out sampling.
module aibcr3aux_red_bittmr #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
`ifdef AUX_RED_READBACK_EN
  output logic rise,
`endif
  output logic tick,
  output logic hi
);
  localparam int PW = $clog2(DIV);

  logic [PW-1:0] ph_q;

  // tick marks the last cycle; the next edge starts a new period
  assign tick = (ph_q == PW'(DIV - 1));
  assign hi   = (ph_q >= PW'(DIV / 2));
`ifdef AUX_RED_READBACK_EN
  assign rise = (ph_q == PW'(DIV / 2 - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= '0;
    end else if (clr || tick) begin
      ph_q <= '0;
    end else begin
      ph_q <= ph_q + PW'(1);
    end
  end

endmodule

// File: rtl/aibcr3aux_red_chain_ld.sv
// Serial loader for the two aux active-redundancy chains, MSB first.
// AUX_RED_READBACK_EN captures prior chain contents during the shift.
module aibcr3aux_red_chain_ld
  import aibcr3aux_red_pkg::*;
#(
  parameter int CHAIN_LEN = 48,
  parameter int DIV       = 4
) (
  input  logic                      i_clk,
  input  logic                      irstb,
  aibcr3aux_red_chain_ld_if.slave   bus
);
  localparam int BW = $clog2(CHAIN_LEN + 1);

  if (!div_ok(DIV) || CHAIN_LEN < 2) begin : g_bad_cfg
    $error("aibcr3aux_red_chain_ld: illegal DIV or CHAIN_LEN");
  end

  state_t               state_q;
  state_t               state_n;
  logic [1:0]           sel_q;
  logic [CHAIN_LEN-1:0] sr1_q;
  logic [CHAIN_LEN-1:0] sr2_q;
  logic [BW-1:0]        bit_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 noop_q;
  logic                 sen1_q;
  logic                 sen2_q;
  logic                 dsel1_q;
  logic                 dsel2_q;
  logic                 txen1_q;
  logic                 txen2_q;
  logic                 tick;
  logic                 hi;
  logic                 clr;
  logic                 accept;
  logic                 noop;
  logic                 last_bit;
  logic                 drive;
`ifdef AUX_RED_READBACK_EN
  logic                 rise;
  logic [CHAIN_LEN-1:0] rb1_q;
  logic [CHAIN_LEN-1:0] rb2_q;
`endif

  assign accept   = (state_q == IDLE) && bus.i_ld_req && (|bus.i_ld_sel);
  assign noop     = (state_q == IDLE) && bus.i_ld_req && (bus.i_ld_sel == 2'b00);
  assign last_bit = (bit_q == BW'(CHAIN_LEN - 1));
  assign clr      = (state_n != state_q) || (state_q == IDLE);
  assign drive    = (state_q == SETUP) || (state_q == SHIFT);

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_n = SETUP;
      SETUP:   if (tick) state_n = SHIFT;
      SHIFT:   if (tick && last_bit) state_n = HOLD;
      HOLD:    if (tick) state_n = APPLY;
      APPLY:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  aibcr3aux_red_bittmr #(
    .DIV   (DIV)
  ) u_bittmr (
    .clk   (i_clk),
    .rst_n (irstb),
    .clr   (clr),
`ifdef AUX_RED_READBACK_EN
    .rise  (rise),
`endif
    .tick  (tick),
    .hi    (hi)
  );

  always_ff @(posedge i_clk or negedge irstb) begin
    if (!irstb) begin
      state_q <= IDLE;
      sel_q   <= '0;
      sr1_q   <= '0;
      sr2_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      noop_q  <= 1'b0;
      sen1_q  <= 1'b0;
      sen2_q  <= 1'b0;
      dsel1_q <= 1'b0;
      dsel2_q <= 1'b0;
      txen1_q <= 1'b0;
      txen2_q <= 1'b0;
    end else begin
      state_q <= state_n;
      noop_q  <= noop;
      done_q  <= noop_q || (state_q == APPLY);
      if (accept) begin
        sel_q  <= bus.i_ld_sel;
        sr1_q  <= bus.i_ld_data1;
        sr2_q  <= bus.i_ld_data2;
        bit_q  <= '0;
        busy_q <= 1'b1;
        sen1_q <= bus.i_ld_sel[SEL_CH1];
        sen2_q <= bus.i_ld_sel[SEL_CH2];
        if (bus.i_ld_sel[SEL_CH1]) begin
          dsel1_q <= 1'b1;
          txen1_q <= 1'b0;
        end
        if (bus.i_ld_sel[SEL_CH2]) begin
          dsel2_q <= 1'b1;
          txen2_q <= 1'b0;
        end
      end
      // advance to the next bit as the period closes
      if (state_q == SHIFT && tick) begin
        sr1_q <= sr1_q << 1;
        sr2_q <= sr2_q << 1;
        bit_q <= bit_q + BW'(1);
        if (last_bit) begin
          sen1_q <= 1'b0;
          sen2_q <= 1'b0;
        end
      end
      if (state_q == HOLD && tick) begin
        if (sel_q[SEL_CH1]) begin
          dsel1_q <= 1'b0;
          txen1_q <= 1'b1;
        end
        if (sel_q[SEL_CH2]) begin
          dsel2_q <= 1'b0;
          txen2_q <= 1'b1;
        end
      end
      if (state_q == APPLY) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.o_ld_busy          = busy_q;
  assign bus.o_ld_done          = done_q;
  assign bus.o_actred1          = drive && sel_q[SEL_CH1] && sr1_q[CHAIN_LEN-1];
  assign bus.o_actred2          = drive && sel_q[SEL_CH2] && sr2_q[CHAIN_LEN-1];
  assign bus.o_red_clk          = (state_q == SHIFT) && hi;
  assign bus.o_shift_en_chain1  = sen1_q;
  assign bus.o_shift_en_chain2  = sen2_q;
  assign bus.o_idataselb_chain1 = dsel1_q;
  assign bus.o_idataselb_chain2 = dsel2_q;
  assign bus.o_actred_txen1     = txen1_q;
  assign bus.o_actred_txen2     = txen2_q;

`ifdef AUX_RED_READBACK_EN
  // scan-out still holds the old bit on the edge that raises red_clk
  always_ff @(posedge i_clk or negedge irstb) begin
    if (!irstb) begin
      rb1_q <= '0;
      rb2_q <= '0;
    end else if (state_q == SHIFT && rise) begin
      if (sel_q[SEL_CH1]) rb1_q <= {rb1_q[CHAIN_LEN-2:0], bus.i_red_so1};
      if (sel_q[SEL_CH2]) rb2_q <= {rb2_q[CHAIN_LEN-2:0], bus.i_red_so2};
    end
  end

  assign bus.o_rb_data1 = rb1_q;
  assign bus.o_rb_data2 = rb2_q;
  assign bus.o_rb_valid = done_q;
`endif

endmodule
